memory_game_core: RTL

//  Parametrised Simon-style game engine: the FPGA builds a pseudo-random symbol sequence one symbol
//  per round, plays it back, then checks the user's entries against it under a per-entry timeout.

---
 rtl/memory_game_core.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/memory_game_core.sv
// memory_game_core: Simon-style engine that grows an LFSR-built sequence, plays it back and checks entries.
// Optional MEMGAME_LIVES_EN adds parameter LIVES and output lives_left (an error replays the round instead of losing).
module memory_game_core #(
    parameter int          SYM_W       = 4,
    parameter int          MAX_LEN     = 16,
    parameter int          SHOW_CYC    = 50_000_000,
    parameter int          TIMEOUT_CYC = 250_000_000,
    parameter logic [15:0] SEED        = 16'hACE1
`ifdef MEMGAME_LIVES_EN
    ,
    parameter int          LIVES       = 3
`endif
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         enter,
    input  logic [SYM_W-1:0]             user_sym,
    output logic [SYM_W-1:0]             show_sym,
    output logic                         show_valid,
    output logic [$clog2(MAX_LEN+1)-1:0] seq_len,
    output logic [$clog2(MAX_LEN+1)-1:0] score,
    output logic                         in_turn,
    output logic                         match,
    output logic                         win,
    output logic                         end_user,
    output logic                         end_time
`ifdef MEMGAME_LIVES_EN
    ,
    output logic [1:0]                   lives_left
`endif
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int IW   = $clog2(MAX_LEN);
    localparam int MAXC = (SHOW_CYC > TIMEOUT_CYC) ? SHOW_CYC : TIMEOUT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [15:0]   SEED_EFF     = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CW-1:0] SHOW_LAST    = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] MAX_LEN_L    = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_SHOW,
        S_INPUT,
        S_WIN,
        S_LOSE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              start_q, start_prev_q;
    logic              enter_q, enter_prev_q;
    logic [LW-1:0]     seq_len_q, seq_len_d;
    logic [LW-1:0]     score_q, score_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     timer_q, timer_d;
    logic              phase_on_q, phase_on_d;
    logic              match_q, match_d;
    logic              end_user_q, end_user_d;
    logic              end_time_q, end_time_d;
`ifdef MEMGAME_LIVES_EN
    logic [1:0]        lives_q, lives_d;
`endif

    logic [SYM_W-1:0]  seq_q [MAX_LEN];
    logic              seq_we;
    logic [SYM_W-1:0]  rd_sym;
    logic [LW-1:0]     last_idx;
    logic              start_edge, enter_edge;
    logic              err_user, err_time;

    assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign start_edge = start_q & ~start_prev_q;
    assign enter_edge = enter_q & ~enter_prev_q;
    assign rd_sym     = seq_q[idx_q[IW-1:0]];
    assign last_idx   = seq_len_q - LW'(1);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED_EFF;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            enter_q      <= 1'b0;
            enter_prev_q <= 1'b0;
            seq_len_q    <= '0;
            score_q      <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            phase_on_q   <= 1'b0;
            match_q      <= 1'b0;
            end_user_q   <= 1'b0;
            end_time_q   <= 1'b0;
`ifdef MEMGAME_LIVES_EN
            lives_q      <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            start_q      <= start;
            start_prev_q <= start_q;
            enter_q      <= enter;
            enter_prev_q <= enter_q;
            seq_len_q    <= seq_len_d;
            score_q      <= score_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            phase_on_q   <= phase_on_d;
            match_q      <= match_d;
            end_user_q   <= end_user_d;
            end_time_q   <= end_time_d;
`ifdef MEMGAME_LIVES_EN
            lives_q      <= lives_d;
`endif
        end
    end

    // Sequence storage is never reset; only entries below seq_len are ever read.
    always_ff @(posedge CLOCK_50) begin
        if (seq_we) begin
            seq_q[seq_len_q[IW-1:0]] <= lfsr_q[SYM_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_len_d  = seq_len_q;
        score_d    = score_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        phase_on_d = phase_on_q;
        match_d    = 1'b0;
        end_user_d = end_user_q;
        end_time_d = end_time_q;
        seq_we     = 1'b0;
        err_user   = 1'b0;
        err_time   = 1'b0;
`ifdef MEMGAME_LIVES_EN
        lives_d    = lives_q;
`endif

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start_edge) begin
                    state_d    = S_GEN;
                    seq_len_d  = '0;
                    score_d    = '0;
                    end_user_d = 1'b0;
                    end_time_d = 1'b0;
`ifdef MEMGAME_LIVES_EN
                    lives_d    = 2'(LIVES);
`endif
                end
            end

            S_GEN: begin
                seq_we     = 1'b1;
                seq_len_d  = seq_len_q + LW'(1);
                state_d    = S_SHOW;
                idx_d      = '0;
                timer_d    = '0;
                phase_on_d = 1'b1;
            end

            // Each symbol is an on-phase followed by an equally long blank gap.
            S_SHOW: begin
                if (timer_q == SHOW_LAST) begin
                    timer_d    = '0;
                    phase_on_d = ~phase_on_q;
                    if (!phase_on_q) begin
                        if (idx_q == last_idx) begin
                            state_d = S_INPUT;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + LW'(1);
                        end
                    end
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end

            // An entry seen on the timeout cycle wins over the timeout.
            S_INPUT: begin
                timer_d = timer_q + CW'(1);
                if (enter_edge) begin
                    if (user_sym == rd_sym) begin
                        match_d = 1'b1;
                        timer_d = '0;
                        if (idx_q == last_idx) begin
                            score_d = score_q + LW'(1);
                            state_d = (seq_len_q == MAX_LEN_L) ? S_WIN : S_GEN;
                        end else begin
                            idx_d = idx_q + LW'(1);
                        end
                    end else begin
                        err_user = 1'b1;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_time = 1'b1;
                end

                if (err_user || err_time) begin
`ifdef MEMGAME_LIVES_EN
                    if (lives_q != 2'd0) begin
                        lives_d    = lives_q - 2'd1;
                        state_d    = S_SHOW;
                        idx_d      = '0;
                        timer_d    = '0;
                        phase_on_d = 1'b1;
                    end else begin
                        state_d    = S_LOSE;
                        end_user_d = err_user;
                        end_time_d = err_time;
                    end
`else
                    state_d    = S_LOSE;
                    end_user_d = err_user;
                    end_time_d = err_time;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign show_valid = (state_q == S_SHOW) && phase_on_q;
    assign show_sym   = show_valid ? rd_sym : '0;
    assign seq_len    = seq_len_q;
    assign score      = score_q;
    assign in_turn    = (state_q == S_INPUT);
    assign match      = match_q;
    assign win        = (state_q == S_WIN);
    assign end_user   = end_user_q;
    assign end_time   = end_time_q;
`ifdef MEMGAME_LIVES_EN
    assign lives_left = lives_q;
`endif

endmodule
